// File: rtl/nonce_sequencer.sv
// Mining control stage: holds header/target/nonce range, serves header words to
// the double SHA-256 wrapper with the live nonce spliced in, and checks each result.
module nonce_sequencer (
  input  logic         clk,
  input  logic         rst,
  input  logic         cfg_we,
  input  logic [4:0]   cfg_addr,
  input  logic [31:0]  cfg_data,
  input  logic         run,
  output logic         hs_start,
  input  logic [4:0]   hs_addr,
  input  logic         hs_rq,
  output logic [31:0]  hs_data,
  output logic         hs_rdy,
  input  logic [255:0] hs_hash,
  input  logic         hs_done,
  output logic         busy,
  output logic         found,
  output logic [31:0]  found_nonce,
  output logic         exhausted,
  output logic [31:0]  hash_count
);

  typedef enum logic [2:0] {
    S_IDLE, S_START, S_WAIT, S_CHECK, S_NEXT, S_FOUND, S_EXHAUSTED
  } state_t;

  state_t        state, state_nx;
  logic [31:0]   header [20];
  logic [31:0]   target [8];
  logic [31:0]   nonce_last;
  logic [31:0]   nonce;
  logic          done_q;
  logic [255:0]  cmp;
  logic [255:0]  tgt_flat;
  logic [31:0]   word;
  logic          hit;
  logic          done_edge;

  // The hasher's result is byte-serial big-endian; the target compare wants the
  // digest's first byte as the least significant one.
  always_comb begin
    cmp      = '0;
    tgt_flat = '0;
    for (int unsigned i = 0; i < 32; i++) cmp[8*i +: 8] = hs_hash[255-8*i -: 8];
    for (int unsigned i = 0; i < 8; i++) tgt_flat[255-32*i -: 32] = target[i];
  end

  assign hit       = (cmp <= tgt_flat);
  assign done_edge = hs_done & ~done_q;

  always_comb begin
    word = '0;
    if (hs_addr < 5'd19)       word = header[hs_addr];
    else if (hs_addr == 5'd19) word = nonce;
    else if (hs_addr == 5'd20) word = 32'h8000_0000;
    else if (hs_addr == 5'd31) word = 32'h0000_0280;
  end

  always_comb begin
    busy = (state == S_START) || (state == S_WAIT) ||
           (state == S_CHECK) || (state == S_NEXT);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    hs_start = 1'b0;
    case (state)
      S_IDLE:  if (run) state_nx = S_START;
      S_START: begin
        hs_start = 1'b1;
        state_nx = run ? S_WAIT : S_IDLE;
      end
      S_WAIT: begin
        if (!run)          state_nx = S_IDLE;
        else if (done_edge) state_nx = S_CHECK;
      end
      S_CHECK: begin
        if (!run)                     state_nx = S_IDLE;
        else if (hit)                 state_nx = S_FOUND;
        else if (nonce == nonce_last) state_nx = S_EXHAUSTED;
        else                          state_nx = S_NEXT;
      end
      S_NEXT:                 state_nx = run ? S_START : S_IDLE;
      S_FOUND, S_EXHAUSTED:   if (!run) state_nx = S_IDLE;
      default:                state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < 20; i++) header[i] <= '0;
      for (int unsigned i = 0; i < 8; i++) target[i] <= '0;
      nonce_last  <= '0;
      nonce       <= '0;
      done_q      <= 1'b0;
      hs_rdy      <= 1'b0;
      hs_data     <= '0;
      found       <= 1'b0;
      found_nonce <= '0;
      exhausted   <= 1'b0;
      hash_count  <= '0;
    end else begin
      done_q <= hs_done;
      hs_rdy <= hs_rq;
      if (hs_rq) hs_data <= word;

      if (cfg_we && !busy) begin
        if (cfg_addr < 5'd20)       header[cfg_addr] <= cfg_data;
        else if (cfg_addr < 5'd28)  target[cfg_addr[2:0] + 3'd4] <= cfg_data;
        else if (cfg_addr == 5'd28) nonce_last <= cfg_data;
      end

      // An abort (run low) suppresses every CHECK/NEXT side effect.
      case (state)
        S_IDLE: if (run) begin
          hash_count <= '0;
          found      <= 1'b0;
          exhausted  <= 1'b0;
          nonce      <= header[19];
        end
        S_CHECK: if (run) begin
          hash_count <= hash_count + 32'd1;
          if (hit) begin
            found       <= 1'b1;
            found_nonce <= nonce;
          end else if (nonce == nonce_last) begin
            exhausted <= 1'b1;
          end
        end
        S_NEXT: if (run) nonce <= nonce + 32'd1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_nonce_sequencer.sv
// Self-checking bench for nonce_sequencer: directed scenarios plus a random
// campaign, all checked every cycle against an in-bench behavioural model.
module tb_nonce_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         cfg_we = 1'b0;
  logic [4:0]   cfg_addr = '0;
  logic [31:0]  cfg_data = '0;
  logic         run = 1'b1;
  logic         hs_start;
  logic [4:0]   hs_addr = '0;
  logic         hs_rq = 1'b0;
  logic [31:0]  hs_data;
  logic         hs_rdy;
  logic [255:0] hs_hash = '0;
  logic         hs_done = 1'b0;
  logic         busy;
  logic         found;
  logic [31:0]  found_nonce;
  logic         exhausted;
  logic [31:0]  hash_count;

  nonce_sequencer dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .run(run), .hs_start(hs_start), .hs_addr(hs_addr), .hs_rq(hs_rq),
    .hs_data(hs_data), .hs_rdy(hs_rdy), .hs_hash(hs_hash), .hs_done(hs_done),
    .busy(busy), .found(found), .found_nonce(found_nonce), .exhausted(exhausted),
    .hash_count(hash_count)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errs   = 0;
  int starts   = 0;

  // Model: phase of the mining job, as seen from outside the block.
  localparam int P_IDLE = 0, P_START = 1, P_WAIT = 2, P_CHECK = 3, P_NEXT = 4,
                 P_FOUND = 5, P_EXH = 6;
  int          m_phase = P_IDLE;
  logic [31:0] m_hdr [20];
  logic [31:0] m_tgt [8];
  logic [31:0] m_last = '0, m_nonce = '0, m_fnonce = '0, m_count = '0, m_data = '0;
  logic        m_found = 0, m_exh = 0, m_rdy = 0, m_dq = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errs++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] byte_rev(input logic [255:0] h);
    logic [255:0] r = '0;
    for (int i = 0; i < 32; i++) r = (r << 8) | ((h >> (8 * i)) & 256'hFF);
    return r;
  endfunction

  function automatic logic [255:0] target_value();
    logic [255:0] t = '0;
    for (int i = 0; i < 8; i++) t = (t << 32) | 256'(m_tgt[i]);
    return t;
  endfunction

  function automatic logic [31:0] served(input int a);
    if (a < 19)  return m_hdr[a];
    if (a == 19) return m_nonce;
    if (a == 20) return 32'h8000_0000;
    if (a == 31) return 32'h0000_0280;
    return 32'h0;
  endfunction

  task automatic model_step();
    logic busy_pre;
    logic edge_seen;
    int   nxt;
    if (rst) begin
      for (int i = 0; i < 20; i++) m_hdr[i] = '0;
      for (int i = 0; i < 8; i++) m_tgt[i] = '0;
      m_last = '0; m_nonce = '0; m_fnonce = '0; m_count = '0; m_data = '0;
      m_found = 0; m_exh = 0; m_rdy = 0; m_dq = 0; m_phase = P_IDLE;
      return;
    end
    m_rdy = hs_rq;
    if (hs_rq) m_data = served(int'(hs_addr));
    edge_seen = hs_done && !m_dq;
    m_dq = hs_done;
    busy_pre = (m_phase >= P_START) && (m_phase <= P_NEXT);
    nxt = m_phase;
    if (m_phase == P_IDLE) begin
      if (run) begin
        m_count = 0; m_found = 0; m_exh = 0; m_nonce = m_hdr[19]; nxt = P_START;
      end
    end else if (m_phase == P_FOUND || m_phase == P_EXH) begin
      if (!run) nxt = P_IDLE;
    end else if (!run) begin
      nxt = P_IDLE;
    end else if (m_phase == P_START) begin
      nxt = P_WAIT;
    end else if (m_phase == P_WAIT) begin
      if (edge_seen) nxt = P_CHECK;
    end else if (m_phase == P_CHECK) begin
      m_count = m_count + 1;
      if (byte_rev(hs_hash) <= target_value()) begin
        m_found = 1; m_fnonce = m_nonce; nxt = P_FOUND;
      end else if (m_nonce == m_last) begin
        m_exh = 1; nxt = P_EXH;
      end else nxt = P_NEXT;
    end else begin
      m_nonce = m_nonce + 1; nxt = P_START;
    end
    if (cfg_we && !busy_pre) begin
      if (cfg_addr < 20)       m_hdr[cfg_addr] = cfg_data;
      else if (cfg_addr < 28)  m_tgt[int'(cfg_addr) - 20] = cfg_data;
      else if (cfg_addr == 28) m_last = cfg_data;
    end
    m_phase = nxt;
  endtask

  task automatic compare();
    chk("hs_start", 64'(hs_start), 64'(m_phase == P_START));
    chk("busy", 64'(busy), 64'((m_phase >= P_START) && (m_phase <= P_NEXT)));
    chk("found", 64'(found), 64'(m_found));
    chk("found_nonce", 64'(found_nonce), 64'(m_fnonce));
    chk("exhausted", 64'(exhausted), 64'(m_exh));
    chk("hash_count", 64'(hash_count), 64'(m_count));
    chk("hs_rdy", 64'(hs_rdy), 64'(m_rdy));
    chk("hs_data", 64'(hs_data), 64'(m_data));
  endtask

  task automatic cyc();
    @(posedge clk);
    model_step();
    #1;
    compare();
    if (hs_start) starts++;
    @(negedge clk);
  endtask

  task automatic cfg_write(input logic [4:0] a, input logic [31:0] d);
    cfg_we = 1'b1; cfg_addr = a; cfg_data = d;
    cyc();
    cfg_we = 1'b0;
  endtask

  task automatic wait_start(input string name);
    for (int i = 0; i < 40; i++) begin
      if (hs_start) return;
      cyc();
    end
    chk({name, "_start_timeout"}, 64'(hs_start), 64'd1);
  endtask

  task automatic req(input logic [4:0] a, output logic [31:0] d);
    hs_addr = a; hs_rq = 1'b1;
    cyc();
    hs_rq = 1'b0;
    chk("req_rdy", 64'(hs_rdy), 64'd1);
    d = hs_data;
  endtask

  task automatic done_pulse(input logic [255:0] h);
    hs_hash = h; hs_done = 1'b1;
    cyc();
    hs_done = 1'b0;
  endtask

  task automatic wait_flag(input string name);
    for (int i = 0; i < 20; i++) begin
      if (found || exhausted) return;
      cyc();
    end
    chk({name, "_flag_timeout"}, 64'(found | exhausted), 64'd1);
  endtask

  function automatic logic [255:0] rand256();
    logic [255:0] r = '0;
    for (int i = 0; i < 8; i++) r = (r << 32) | 256'($urandom);
    return r;
  endfunction

  initial begin
    logic [31:0] d;
    logic [31:0] seen [4];
    logic [4:0]  addrs [6];
    logic [31:0] want [6];
    int s0;

    // Reset held with run high: everything zero, then one start after release.
    cyc(); cyc();
    chk("rst_start", 64'(hs_start), 64'd0);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_found", 64'(found), 64'd0);
    chk("rst_count", 64'(hash_count), 64'd0);
    chk("rst_rdy", 64'(hs_rdy), 64'd0);
    rst = 1'b0;
    cyc();
    chk("rel_start", 64'(hs_start), 64'd1);
    chk("rel_busy", 64'(busy), 64'd1);
    run = 1'b0;
    cyc();
    chk("abort_busy", 64'(busy), 64'd0);

    // Request map and immediate hit.
    for (int i = 0; i < 19; i++) cfg_write(5'(i), 32'h1000 + 32'(i));
    cfg_write(5'd19, 32'hDEAD_BEEF);
    for (int i = 0; i < 8; i++) cfg_write(5'(20 + i), 32'hFFFF_FFFF);
    addrs = '{5'd0, 5'd18, 5'd19, 5'd20, 5'd25, 5'd31};
    want  = '{32'h1000, 32'h1012, 32'hDEAD_BEEF, 32'h8000_0000, 32'h0, 32'h280};
    s0 = starts;
    run = 1'b1;
    wait_start("hit");
    for (int i = 0; i < 6; i++) begin
      req(addrs[i], d);
      chk("map_word", 64'(d), 64'(want[i]));
    end
    done_pulse(rand256());
    wait_flag("hit");
    chk("hit_found", 64'(found), 64'd1);
    chk("hit_nonce", 64'(found_nonce), 64'hDEAD_BEEF);
    chk("hit_count", 64'(hash_count), 64'd1);
    chk("hit_starts", 64'(starts - s0), 64'd1);

    // Range wrapping through zero with an unreachable target.
    run = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) cfg_write(5'(20 + i), 32'h0);
    cfg_write(5'd19, 32'hFFFF_FFFE);
    cfg_write(5'd28, 32'h0000_0001);
    s0 = starts;
    run = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_start("wrap");
      req(5'd19, seen[k]);
      done_pulse(rand256() | 256'h1);
    end
    wait_flag("wrap");
    chk("wrap_n0", 64'(seen[0]), 64'hFFFF_FFFE);
    chk("wrap_n1", 64'(seen[1]), 64'hFFFF_FFFF);
    chk("wrap_n2", 64'(seen[2]), 64'h0);
    chk("wrap_n3", 64'(seen[3]), 64'h1);
    chk("wrap_exh", 64'(exhausted), 64'd1);
    chk("wrap_found", 64'(found), 64'd0);
    chk("wrap_count", 64'(hash_count), 64'd4);
    chk("wrap_starts", 64'(starts - s0), 64'd4);

    // Byte order: hash byte 31 lands as the compare MSB.
    run = 1'b0;
    cyc();
    cfg_write(5'd20, 32'hFF00_0000);
    run = 1'b1;
    wait_start("bo_hit");
    req(5'd0, d);
    done_pulse(256'hFF);
    wait_flag("bo_hit");
    chk("bo_hit_found", 64'(found), 64'd1);
    chk("bo_hit_nonce", 64'(found_nonce), 64'hFFFF_FFFE);
    run = 1'b0;
    cyc();
    cfg_write(5'd20, 32'hFEFF_FFFF);
    for (int i = 1; i < 8; i++) cfg_write(5'(20 + i), 32'hFFFF_FFFF);
    cfg_write(5'd28, 32'hFFFF_FFFE);
    run = 1'b1;
    wait_start("bo_miss");
    req(5'd0, d);
    done_pulse(256'hFF);
    wait_flag("bo_miss");
    chk("bo_miss_found", 64'(found), 64'd0);
    chk("bo_miss_exh", 64'(exhausted), 64'd1);

    // Abort mid-hash; config writes while busy are dropped.
    run = 1'b0;
    cyc();
    for (int i = 0; i < 8; i++) cfg_write(5'(20 + i), 32'h0);
    cfg_write(5'd28, 32'h0000_0005);
    run = 1'b1;
    wait_start("abort");
    req(5'd0, d);
    cfg_write(5'd0, 32'h0000_0BAD);
    run = 1'b0;
    cyc();
    chk("ab_busy", 64'(busy), 64'd0);
    done_pulse(256'h1);
    cyc(); cyc();
    chk("ab_found", 64'(found), 64'd0);
    chk("ab_exh", 64'(exhausted), 64'd0);
    chk("ab_count", 64'(hash_count), 64'd0);
    req(5'd0, d);
    chk("ab_readback", 64'(d), 64'h1000);

    // Random campaign.
    for (int c = 0; c < 4000; c++) begin
      rst     = ($urandom_range(0, 599) == 0);
      if ($urandom_range(0, 29) == 0) run = ~run;
      hs_rq   = 1'($urandom);
      hs_addr = 5'($urandom);
      hs_done = ($urandom_range(0, 4) == 0);
      if ($urandom_range(0, 2) == 0) hs_hash = rand256();
      cfg_we   = ($urandom_range(0, 5) == 0);
      cfg_addr = 5'($urandom);
      cfg_data = (cfg_addr == 5'd28) ? m_hdr[19] + 32'($urandom_range(0, 3)) : $urandom;
      cyc();
    end
    rst = 1'b0; cfg_we = 1'b0; hs_rq = 1'b0; hs_done = 1'b0;

    $display("Result: errors=%0d of %0d checks", n_errs, n_checks);
    $finish;
  end

endmodule
